instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 4: prefetch queue entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 imem_addr  output  32  byte address driven to the instruction memory; word index is imem_addr[31:2].
REQ-006 imem_instr  input  32  instruction word returned combinationally, same cycle, for imem_addr.
REQ-007 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc (branch/jump/trap).
REQ-008 redirect_pc  input  32  restart byte address.
REQ-009 out_valid  output  1  queue head holds a valid instruction.
REQ-010 out_ready  input  1  consumer accepts the head this cycle.
REQ-011 out_instr  output  32  instruction at queue head.
REQ-012 out_pc  output  32  byte address of out_instr.
REQ-013 misaligned  output  1  one-cycle pulse: last redirect target had nonzero bits [1:0].

Function
REQ-014 The block SHALL hold fetch_pc, a DEPTH-entry circular queue of {pc, instr}, and pointers wr_ptr, rd_ptr plus count (0..DEPTH).
REQ-015 imem_addr SHALL equal fetch_pc combinationally at all times.
REQ-016 pop SHALL occur when out_valid && out_ready && !redirect_valid; rd_ptr advances mod DEPTH.
REQ-017 push SHALL occur when !redirect_valid && (count < DEPTH || pop); it writes {fetch_pc, imem_instr} at wr_ptr, advances wr_ptr mod DEPTH, and sets fetch_pc <= fetch_pc + 4.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; full queue with pop SHALL still push (sustained 1 instr/cycle).
REQ-019 Full queue without pop SHALL hold fetch_pc, queue contents and outputs stable (stall).
REQ-020 out_valid SHALL be count != 0; out_instr/out_pc SHALL show the entry at rd_ptr, registered values only (no combinational path from imem_instr).
REQ-021 fetch_pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 redirect_valid SHALL take priority over push and pop: queue flushed (count, rd_ptr, wr_ptr <= 0), fetch_pc <= {redirect_pc[31:2], 2'b00}, no push that cycle.
REQ-023 A handshake coinciding with redirect_valid SHALL be discarded by this block; the consumer owns squashing it.
REQ-024 Redirect latency: redirect in cycle N -> imem_addr = target in N+1, first push N+1, out_valid=1 with out_pc = target in N+2.
REQ-025 misaligned SHALL be 1 in cycle N+1 iff redirect in cycle N had redirect_pc[1:0] != 0; 0 otherwise.
REQ-026 Back-to-back redirects SHALL each apply; only the last one determines fetch_pc.
REQ-027 Queue-entry contents past count are don't-care, but SHALL never be presented with out_valid=1.

Reset
REQ-028 While reset=1 at an edge: fetch_pc <= RESET_PC, count/rd_ptr/wr_ptr <= 0, misaligned <= 0; reset overrides redirect, push and pop.
REQ-029 Outputs after reset edge: out_valid=0, misaligned=0, imem_addr=RESET_PC; out_instr/out_pc = 0.
REQ-030 First push SHALL be in the first cycle with reset=0; out_valid=1 from the following cycle.
REQ-031 Reset asserted mid-stream SHALL drop all queued entries with no pop reported afterwards.

Verification
REQ-032 Reset, memory word i = 32'h1000_0000+i, out_ready=1 -> out_pc 0x0,0x4,0x8,... one per cycle from cycle 2; out_instr 0x1000_0000,0x1000_0001,...
REQ-033 out_ready=0 for 10 cycles -> count saturates at 4, imem_addr holds 0x10, out_pc holds 0x0; release -> 0x0..0x0C then 0x10 with no gap or duplicate.
REQ-034 Redirect to 0x40 while queue full -> next cycle imem_addr=0x40, out_valid=0; cycle after: out_pc=0x40, out_instr=word 16; misaligned stays 0.
REQ-035 Redirect to 0x46 -> misaligned pulses one cycle, out_pc=0x44.
REQ-036 RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-037 reset asserted with 3 queued entries and redirect_valid=1 -> next cycle out_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives the instruction memory address, captures the
// returned word into a small circular prefetch queue and presents the oldest
// entry to the consumer with a valid/ready handshake. A redirect flushes the
// queue and restarts fetch at the (word-aligned) target.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misaligned
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_q_instr [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_misaligned;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;

  // Handshake decode: a redirect squashes both the pop and the push.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    w_valid = 1'b0;
    w_pop   = 1'b0;
    w_push  = 1'b0;
    w_valid = (r_count != '0);
    if (!reset && !redirect_valid) begin
      w_pop  = w_valid && out_ready;
      w_push = (r_count < DEPTH_C) || w_pop;
    end
  end

  // Control state: fetch address, pointers, occupancy and misalignment flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc   <= {redirect_pc[31:2], 2'b00};
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_misaligned <= (redirect_pc[1:0] != 2'b00);
    end else begin
      r_misaligned <= 1'b0;
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;  // wraps naturally modulo 2^32
        r_wr_ptr   <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: the queue array is deliberately not reset; entries past count are never shown as valid.
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
      r_q_instr[r_wr_ptr] <= imem_instr;
    end
  end

  // Outputs come from registers only; the head is zeroed while the queue is empty.
  always_comb begin
    imem_addr  = r_fetch_pc;
    out_valid  = w_valid;
    misaligned = r_misaligned;
    out_pc     = '0;
    out_instr  = '0;
    if (w_valid) begin
      out_pc    = r_q_pc[r_rd_ptr];
      out_instr = r_q_instr[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized stretch,
// all compared each cycle against a queue-based behavioural model.
module tb_instruction_fetch;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misaligned;

  logic        reset2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_instr2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic [31:0] out_pc2;
  logic        misaligned2;

  int vectors;
  int miscompares;

  entry_t      m_q[$];
  logic [31:0] m_fetch;
  logic        m_mis;
  logic        m_known;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_instr  = mem_word(imem_addr);
  assign imem_instr2 = mem_word(imem_addr2);

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misaligned     (misaligned)
  );

  instruction_fetch #(.RESET_PC(RESET_PC2), .DEPTH(DEPTH)) dut_wrap (
    .clk            (clk),
    .reset          (reset2),
    .imem_addr      (imem_addr2),
    .imem_instr     (imem_instr2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (out_valid2),
    .out_ready      (1'b1),
    .out_instr      (out_instr2),
    .out_pc         (out_pc2),
    .misaligned     (misaligned2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_edge(input logic rst, input logic rv, input logic [31:0] rpc,
                            input logic rdy);
    if (rst) begin
      m_q.delete();
      m_fetch = RESET_PC;
      m_mis   = 1'b0;
      m_known = 1'b1;
    end else if (rv) begin
      m_q.delete();
      m_fetch = {rpc[31:2], 2'b00};
      m_mis   = (rpc[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (m_q.size() < DEPTH) begin
        m_q.push_back('{pc: m_fetch, instr: mem_word(m_fetch)});
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  // One clock cycle: drive inputs, compare mid-cycle, step model at the edge.
  task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    if (m_known) begin
      check("imem_addr", imem_addr, m_fetch);
      check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("misaligned", 32'(misaligned), 32'(m_mis));
      if (m_q.size() != 0) begin
        check("out_pc", out_pc, m_q[0].pc);
        check("out_instr", out_instr, m_q[0].instr);
      end
    end
    @(posedge clk);
    model_edge(rst, rv, rpc, rdy);
    #1;
  endtask

  initial begin
    logic [31:0] wrap_pc [4];
    vectors     = 0;
    miscompares = 0;
    m_known     = 1'b0;
    m_fetch     = RESET_PC;
    m_mis       = 1'b0;
    reset2      = 1'b1;
    wrap_pc     = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // Reset state.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_misaligned", 32'(misaligned), 32'h0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    // Streaming at one instruction per cycle.
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("first_push_valid_next", 32'(out_valid), 32'h1);
    check("first_out_pc", out_pc, 32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall with a full queue, then release.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("stall_imem_addr", imem_addr, 32'h10);
    check("stall_out_pc", out_pc, 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while full, with a coinciding handshake that must be discarded.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b1);
    check("redir_imem_addr", imem_addr, 32'h40);
    check("redir_out_valid", 32'(out_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_out_pc", out_pc, 32'h40);
    check("redir_out_instr", out_instr, 32'h1000_0010);
    check("redir_misaligned", 32'(misaligned), 32'h0);

    // Misaligned redirect.
    cycle(1'b0, 1'b1, 32'h46, 1'b1);
    check("mis_pulse", 32'(misaligned), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis_out_pc", out_pc, 32'h44);
    check("mis_cleared", 32'(misaligned), 32'h0);

    // Back-to-back redirects: the last one wins.
    cycle(1'b0, 1'b1, 32'h100, 1'b1);
    cycle(1'b0, 1'b1, 32'h207, 1'b1);
    check("b2b_imem_addr", imem_addr, 32'h204);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with three queued entries and a simultaneous redirect.
    cycle(1'b0, 1'b1, 32'h80, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h300, 1'b1);
    check("rst_mid_out_valid", 32'(out_valid), 32'h0);
    check("rst_mid_imem_addr", imem_addr, RESET_PC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        rst_r;
      logic        rv_r;
      logic [31:0] rpc_r;
      logic        rdy_r;
      rst_r = ($urandom_range(0, 49) == 0);
      rv_r  = ($urandom_range(0, 7) == 0);
      rpc_r = $urandom;
      if ($urandom_range(0, 3) == 0) rpc_r = 32'hFFFF_FFF0 | (rpc_r & 32'hF);
      rdy_r = ($urandom_range(0, 2) != 0);
      cycle(rst_r, rv_r, rpc_r, rdy_r);
    end

    // Fetch address wrap-around from a high reset address.
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    @(negedge clk);
    check("wrap_first_invalid", 32'(out_valid2), 32'h0);
    check("wrap_imem_addr", imem_addr2, RESET_PC2);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_out_valid", 32'(out_valid2), 32'h1);
      check("wrap_out_pc", out_pc2, wrap_pc[i]);
      check("wrap_out_instr", out_instr2, mem_word(wrap_pc[i]));
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
